square_iter: RTL and testbench

//  Iterative integer squarer: dt_o = dt_i * dt_i, computed by shift-and-add, one multiplier
//  bit per cycle. It is the inverse of the iterative square-root block and sits beside it in
//  the arithmetic datapath. It is used to regenerate squares from roots and to build

---
 rtl/sqr_pkg.sv | 20 ++
 rtl/square_iter.sv | 102 ++++++++++
 tb/tb_square_iter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqr_pkg.sv
// ----------------------------------------------------------------------------
// sqr_pkg
// Shared types and helpers for the iterative squarer (square_iter).
//   sq_state_e : control FSM states (IDLE -> CALC -> DONE -> IDLE)
//   sqr_cnt_w  : width of the step counter for a given operand width
// ----------------------------------------------------------------------------
package sqr_pkg;

    typedef enum logic [1:0] {
        SQ_IDLE = 2'd0,
        SQ_CALC = 2'd1,
        SQ_DONE = 2'd2
    } sq_state_e;

    // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=1.
    function automatic int sqr_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : sqr_pkg

// File: rtl/square_iter.sv
// ----------------------------------------------------------------------------
// square_iter
// Iterative unsigned squarer: dt_o = dt_i * dt_i using shift-and-add, one
// multiplier bit per clock. Fixed latency of WIDTH cycles from accept to
// out_valid_o, independent of the operand value.
//
// Ports
//   clk_i        in   clock, rising edge
//   rstn_i       in   asynchronous active-low reset
//   enb_i        in   block enable; low aborts any operation in flight
//   in_valid_i   in   operand valid
//   in_ready_o   out  block can accept an operand (IDLE and enabled)
//   dt_i         in   operand, unsigned, WIDTH bits
//   out_valid_o  out  result valid, held until consumed
//   out_ready_i  in   downstream accepts the result
//   dt_o         out  registered result, unsigned, 2*WIDTH bits
//   busy_o       out  high while in CALC or DONE
// ----------------------------------------------------------------------------
module square_iter
    import sqr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 enb_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     dt_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   dt_o,
    output logic                 busy_o
);

    localparam int            CW       = sqr_cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sq_state_e            state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   dt_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CW-1:0]        cnt_q;

    logic [2*WIDTH-1:0]   acc_step;
    logic                 accept;
    logic                 last_step;

    // Ready is also masked by reset so every output reads 0 while held in reset.
    assign in_ready_o  = rstn_i & enb_i & (state_q == SQ_IDLE);
    assign accept      = in_valid_i & in_ready_o;
    assign out_valid_o = (state_q == SQ_DONE);
    assign busy_o      = (state_q == SQ_CALC) || (state_q == SQ_DONE);
    assign dt_o        = dt_q;

    // Accumulator value after the current step; also the final product on the last step.
    assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign last_step = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        if (!enb_i) begin
            state_d = SQ_IDLE;
        end else begin
            case (state_q)
                SQ_IDLE: if (accept)      state_d = SQ_CALC;
                SQ_CALC: if (last_step)   state_d = SQ_DONE;
                SQ_DONE: if (out_ready_i) state_d = SQ_IDLE;
                default:                  state_d = SQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= SQ_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            dt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mcand_q  <= {{WIDTH{1'b0}}, dt_i};
                mplier_q <= dt_i;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (enb_i && (state_q == SQ_CALC)) begin
                acc_q    <= acc_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
                if (last_step) begin
                    dt_q <= acc_step;
                end
            end
        end
    end

endmodule : square_iter

// File: tb/tb_square_iter.sv
// ----------------------------------------------------------------------------
// tb_square_iter
// Directed self-checking bench for square_iter (WIDTH=8). Inputs are driven
// and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_square_iter;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        enb_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  dt_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] dt_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    square_iter #(.WIDTH(8)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .enb_i       (enb_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .dt_i        (dt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .dt_o        (dt_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait (bounded) for in_ready_o, then present one operand for one edge.
    // Afterwards dt_i is scrambled to show the operand was captured at accept.
    task automatic start_op(input logic [7:0] v);
        int n;
        n = 0;
        while (!in_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL start_ready got=%b want=1", in_ready_o);
        end
        in_valid_i = 1'b1;
        dt_i       = v;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        dt_i       = ~v;
    endtask

    // Count falling edges after the accept edge until out_valid_o rises (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid_o && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; enb_i = 1'b1; in_valid_i = 1'b0; dt_i = 8'd0; out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({dt_o, out_valid_o, busy_o, in_ready_o} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got dt=%0d v=%b b=%b r=%b want all 0",
                     dt_o, out_valid_o, busy_o, in_ready_o);
        end
        rstn_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready got r=%b b=%b want r=1 b=0", in_ready_o, busy_o);
        end
        enb_i = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL ready_disabled got=%b want=0", in_ready_o);
        end
        enb_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        int lat;
        out_ready_i = 1'b1;
        start_op(8'd13);
        wait_result(lat);
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=8", lat);
        end
        checks++;
        if (dt_o !== 16'd169) begin
            failures++;
            $display("FAIL basic_13 got=%0d want=169", dt_o);
        end
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_consumed got=%b want=0", out_valid_o);
        end
    endtask

    task automatic test_values();
        int lat;
        logic [7:0]  ops [2] = '{8'd255, 8'd0};
        logic [15:0] exps[2] = '{16'hFE01, 16'h0000};
        out_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_op(ops[i]);
            wait_result(lat);
            checks++;
            if (lat !== 8) begin
                failures++;
                $display("FAIL values_latency op=%0d got=%0d want=8", ops[i], lat);
            end
            checks++;
            if (dt_o !== exps[i]) begin
                failures++;
                $display("FAIL values_result op=%0d got=%0d want=%0d", ops[i], dt_o, exps[i]);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready_i = 1'b0;
        start_op(8'd13);
        wait_result(lat);
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL bp_latency got=%0d want=8", lat);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dt_o !== 16'd169 || out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got dt=%0d v=%b r=%b want dt=169 v=1 r=0",
                         i, dt_o, out_valid_o, in_ready_o);
            end
            @(negedge clk_i);
        end
        // Offer a new operand in the consume cycle: it must not be taken.
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        dt_i        = 8'd5;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || dt_o !== 16'd169) begin
            failures++;
            $display("FAIL bp_consume got v=%b b=%b dt=%0d want v=0 b=0 dt=169",
                     out_valid_o, busy_o, dt_o);
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_abort();
        int lat;
        out_ready_i = 1'b1;
        start_op(8'd200);
        repeat (3) @(negedge clk_i);
        enb_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || dt_o !== 16'd169 || in_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_calc got b=%b v=%b dt=%0d r=%b want b=0 v=0 dt=169 r=0",
                     busy_o, out_valid_o, dt_o, in_ready_o);
        end
        enb_i = 1'b1;
        start_op(8'd200);
        wait_result(lat);
        checks++;
        if (lat !== 8 || dt_o !== 16'd40000) begin
            failures++;
            $display("FAIL abort_rerun got lat=%0d dt=%0d want lat=8 dt=40000", lat, dt_o);
        end
        @(negedge clk_i);
        // Abort while a result is pending in DONE: it is dropped, dt_o holds.
        out_ready_i = 1'b0;
        start_op(8'd3);
        wait_result(lat);
        checks++;
        if (out_valid_o !== 1'b1 || dt_o !== 16'd9) begin
            failures++;
            $display("FAIL abort_pre got v=%b dt=%0d want v=1 dt=9", out_valid_o, dt_o);
        end
        enb_i = 1'b0;
        @(negedge clk_i);
        enb_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || dt_o !== 16'd9) begin
            failures++;
            $display("FAIL abort_done got v=%b b=%b dt=%0d want v=0 b=0 dt=9",
                     out_valid_o, busy_o, dt_o);
        end
        out_ready_i = 1'b1;
    endtask

    task automatic test_async_reset();
        int lat;
        out_ready_i = 1'b1;
        start_op(8'd7);
        repeat (3) @(negedge clk_i);
        #2;
        rstn_i = 1'b0;
        #1;
        checks++;
        if ({dt_o, out_valid_o, busy_o, in_ready_o} !== 19'd0) begin
            failures++;
            $display("FAIL async_reset got dt=%0d v=%b b=%b r=%b want all 0",
                     dt_o, out_valid_o, busy_o, in_ready_o);
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        start_op(8'd7);
        wait_result(lat);
        checks++;
        if (lat !== 8 || dt_o !== 16'd49) begin
            failures++;
            $display("FAIL post_reset got lat=%0d dt=%0d want lat=8 dt=49", lat, dt_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        int  n;
        bit  got;
        for (int x = 1; x <= 255; x++) begin
            out_ready_i = 1'b0;
            start_op(8'(x));
            got = 1'b0;
            n   = 0;
            while (!got && n < 200) begin
                if (out_valid_o) begin
                    out_ready_i = 1'($urandom_range(0, 1));
                    if (out_ready_i) begin
                        got = 1'b1;
                        checks++;
                        if (dt_o !== 16'(x * x)) begin
                            failures++;
                            $display("FAIL b2b_result op=%0d got=%0d want=%0d", x, dt_o, x * x);
                        end
                    end
                end
                @(negedge clk_i);
                n++;
            end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL b2b_timeout op=%0d got=no result want=result", x);
            end
            out_ready_i = 1'b0;
            checks++;
            if (out_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL b2b_dup op=%0d got v=%b want v=0", x, out_valid_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_square_iter
